// File: rtl/bw_write_queue_pkg.sv
// Shared definitions for the bridge write queue: default bus widths, the
// accepted address window, the FIFO depth and the combined entry width.
// The optional drop counter is enabled by defining BW_QUEUE_DROP_COUNT_EN.
package bw_write_queue_pkg;

  localparam int BW_AW         = 16;
  localparam int BW_DW         = 32;
  localparam int BW_DEPTH_LOG2 = 4;
  localparam int BW_ENTRY_W    = BW_AW + BW_DW;

  localparam logic [BW_AW-1:0] BW_WIN_LO = 16'h0010;
  localparam logic [BW_AW-1:0] BW_WIN_HI = 16'h00ff;

endpackage

// File: rtl/bw_write_queue_if.sv
// Bundle of the bridge-side write strobe and the target-side drain handshake.
// The slave modport is the queue's view; the master modport is the
// environment's view (bridge + target).
// drop_count exists only when BW_QUEUE_DROP_COUNT_EN is defined.
interface bw_write_queue_if
  import bw_write_queue_pkg::*;
#(
  parameter int AW         = BW_AW,
  parameter int DW         = BW_DW,
  parameter int DEPTH_LOG2 = BW_DEPTH_LOG2
);

  logic                  bw_write;
  logic [AW-1:0]         bw_addr;
  logic [DW-1:0]         bw_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         out_addr;
  logic [DW-1:0]         out_data;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  reject;
`ifdef BW_QUEUE_DROP_COUNT_EN
  logic [7:0]            drop_count;
`endif

  modport slave (
    input  bw_write, bw_addr, bw_data, out_ready,
    output out_valid, out_addr, out_data, level, overflow, reject
`ifdef BW_QUEUE_DROP_COUNT_EN
    , output drop_count
`endif
  );

  modport master (
    output bw_write, bw_addr, bw_data, out_ready,
    input  out_valid, out_addr, out_data, level, overflow, reject
`ifdef BW_QUEUE_DROP_COUNT_EN
    , input drop_count
`endif
  );

endinterface

// File: rtl/bw_queue_mem.sv
// Storage array for the write queue: one write port and one read port whose
// address is registered, so rdata always reflects the current contents of
// the slot addressed at the previous edge.
module bw_queue_mem
  import bw_write_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = BW_DEPTH_LOG2,
  parameter int EW         = BW_ENTRY_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [EW-1:0]         wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [EW-1:0]         rdata
);

  logic [EW-1:0]         mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] raddr_q;

  // Write the addressed slot and capture the read address every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/bw_write_queue.sv
// Write buffer behind the narrow-to-wide bridge. Window-filters incoming
// write strobes, queues accepted ones and drains them over valid/ready.
// The head entry is held in dedicated registers; the array read port
// always looks one slot past the head so a pop can refill the head in the
// same edge. Define BW_QUEUE_DROP_COUNT_EN to add a saturating drop counter.
module bw_write_queue
  import bw_write_queue_pkg::*;
#(
  parameter int            DEPTH_LOG2 = BW_DEPTH_LOG2,
  parameter int            AW         = BW_AW,
  parameter int            DW         = BW_DW,
  parameter logic [AW-1:0] WIN_LO     = AW'(BW_WIN_LO),
  parameter logic [AW-1:0] WIN_HI     = AW'(BW_WIN_HI)
) (
  input  logic             clk,
  input  logic             rst,
  bw_write_queue_if.slave  bw
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = AW + DW;

  logic [PW-1:0] wptr, rptr, level_q;
  logic [PW-1:0] rptr_nxt, rptr_ahead;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          overflow_q, reject_q;
  logic          in_win, wr_attempt, empty, full, push, pop, drop_evt;
  logic [EW-1:0] rd_entry;

  // Out-of-window writes are rejected before any FIFO consideration, so
  // reject wins over overflow. bw_write gates every use of the address.
  assign in_win     = (bw.bw_addr >= WIN_LO) && (bw.bw_addr <= WIN_HI);
  assign wr_attempt = bw.bw_write && in_win;
  assign empty      = (level_q == '0);
  assign full       = (level_q == PW'(DEPTH));
  assign pop        = !empty && bw.out_ready;
  assign push       = wr_attempt && (!full || pop);
  assign drop_evt   = wr_attempt && full && !pop;

  assign rptr_nxt   = rptr + PW'(pop);
  assign rptr_ahead = rptr_nxt + PW'(1);

  bw_queue_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .EW         (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[DEPTH_LOG2-1:0]),
    .wdata ({bw.bw_addr, bw.bw_data}),
    .raddr (rptr_ahead[DEPTH_LOG2-1:0]),
    .rdata (rd_entry)
  );

  // Pointers, occupancy and the one-cycle drop/reject pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      wptr       <= wptr + PW'(push);
      rptr       <= rptr_nxt;
      level_q    <= level_q + PW'(push) - PW'(pop);
      overflow_q <= drop_evt;
      reject_q   <= bw.bw_write && !in_win;
    end
  end

  // Head load: the incoming word when the queue is (or becomes) empty
  // underneath it, otherwise the next stored entry on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_addr <= '0;
      head_data <= '0;
    end else if (push && (empty || (pop && level_q == PW'(1)))) begin
      head_addr <= bw.bw_addr;
      head_data <= bw.bw_data;
    end else if (pop && level_q > PW'(1)) begin
      head_addr <= rd_entry[EW-1:DW];
      head_data <= rd_entry[DW-1:0];
    end
  end

  assign bw.out_valid = !empty;
  assign bw.out_addr  = head_addr;
  assign bw.out_data  = head_data;
  assign bw.level     = level_q;
  assign bw.overflow  = overflow_q;
  assign bw.reject    = reject_q;

`ifdef BW_QUEUE_DROP_COUNT_EN
  logic [7:0] drop_cnt;

  // Saturating count of full-queue drops; rejects are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_evt && drop_cnt != 8'hff) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bw.drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_bw_write_queue.sv
// Self-checking bench for bw_write_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_bw_write_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bw_write_queue_if bus ();

  bw_write_queue dut (
    .clk (clk),
    .rst (rst),
    .bw  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] model_q[$];
  int          drops_exp = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model after an edge.
  task automatic check_outputs(input string tag, input bit exp_ovf, input bit exp_rej);
    check_val({tag, " level"}, 64'(bus.level), 64'(model_q.size()));
    check_val({tag, " out_valid"}, 64'(bus.out_valid), 64'(model_q.size() != 0));
    check_val({tag, " overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    check_val({tag, " reject"}, 64'(bus.reject), 64'(exp_rej));
    if (model_q.size() != 0) begin
      check_val({tag, " out_addr"}, 64'(bus.out_addr), 64'(model_q[0][47:32]));
      check_val({tag, " out_data"}, 64'(bus.out_data), 64'(model_q[0][31:0]));
    end
`ifdef BW_QUEUE_DROP_COUNT_EN
    check_val({tag, " drop_count"}, 64'(bus.drop_count), 64'(drops_exp));
`endif
  endtask

  // One clock: drive inputs, advance the model by the queue rules, check.
  task automatic cycle(input string tag, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic rdy);
    bit pop_m, in_win, exp_ovf, exp_rej;
    bus.bw_write  = wr;
    bus.bw_addr   = wr ? a : 'x;
    bus.bw_data   = wr ? d : 'x;
    bus.out_ready = rdy;
    pop_m   = (model_q.size() != 0) && rdy;
    in_win  = (a >= 16'h0010) && (a <= 16'h00ff);
    exp_ovf = 1'b0;
    exp_rej = 1'b0;
    @(posedge clk);
    #1;
    if (pop_m) void'(model_q.pop_front());
    if (wr) begin
      if (!in_win) exp_rej = 1'b1;
      else if (model_q.size() == 16) begin
        exp_ovf = 1'b1;
        if (drops_exp < 255) drops_exp++;
      end else model_q.push_back({a, d});
    end
    check_outputs(tag, exp_ovf, exp_rej);
  endtask

  task automatic idle(input string tag, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 16'h0, 32'h0, rdy);
  endtask

  initial begin
    bus.bw_write  = 1'b0;
    bus.bw_addr   = '0;
    bus.bw_data   = '0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst level", 64'(bus.level), 64'd0);
    check_val("rst out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst out_addr", 64'(bus.out_addr), 64'd0);
    check_val("rst out_data", 64'(bus.out_data), 64'd0);
    check_val("rst overflow", 64'(bus.overflow), 64'd0);
    check_val("rst reject", 64'(bus.reject), 64'd0);
`ifdef BW_QUEUE_DROP_COUNT_EN
    check_val("rst drop_count", 64'(bus.drop_count), 64'd0);
`endif
    rst = 1'b0;

    // Pass-through with the target always ready.
    cycle("t1", 1'b1, 16'h0010, 32'h11111111, 1'b1);
    cycle("t1", 1'b1, 16'h0011, 32'h22222222, 1'b1);
    cycle("t1", 1'b1, 16'h0012, 32'h33333333, 1'b1);
    idle("t1", 2, 1'b1);

    // Fill to full with the target stalled, then one more write drops.
    for (int i = 0; i < 16; i++) cycle("t2 fill", 1'b1, 16'(16'h20 + i), $urandom, 1'b0);
    cycle("t2 ovf", 1'b1, 16'h0030, 32'hdead0030, 1'b0);
    idle("t2 drain", 18, 1'b1);

    // Full queue, simultaneous pop and push.
    for (int i = 0; i < 16; i++) cycle("t3 fill", 1'b1, 16'(16'h50 + i), $urandom, 1'b0);
    cycle("t3 push+pop", 1'b1, 16'h0040, 32'h40404040, 1'b1);
    idle("t3 drain", 18, 1'b1);

    // Window edges just outside and exactly on the limits.
    cycle("t4 lo-1", 1'b1, 16'h000f, 32'h0000000f, 1'b0);
    cycle("t4 hi+1", 1'b1, 16'h0100, 32'h00000100, 1'b0);
    cycle("t4 hi", 1'b1, 16'h00ff, 32'h000000ff, 1'b1);
    idle("t4", 2, 1'b1);

    // Asynchronous reset in the middle of a backlog.
    for (int i = 0; i < 5; i++) cycle("t5 fill", 1'b1, 16'(16'h60 + i), $urandom, 1'b0);
    rst = 1'b1;
    #1;
    check_val("t5 async out_valid", 64'(bus.out_valid), 64'd0);
    check_val("t5 async level", 64'(bus.level), 64'd0);
    check_val("t5 async out_addr", 64'(bus.out_addr), 64'd0);
    rst = 1'b0;
    model_q.delete();
    drops_exp = 0;
    cycle("t5 after", 1'b1, 16'h0022, 32'hcafef00d, 1'b1);
    idle("t5 after", 2, 1'b1);

    // Randomized traffic with phases of varying target readiness.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 120; i++) begin
        logic        wr, rdy;
        logic [15:0] a;
        wr  = ($urandom_range(0, 3) != 0);
        rdy = (p % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        a   = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 16'h1ff))
                                          : 16'($urandom_range(16'h10, 16'hff));
        cycle("rand", wr, a, $urandom, rdy);
      end
    end
    idle("rand drain", 20, 1'b1);

`ifdef BW_QUEUE_DROP_COUNT_EN
    // Drive the drop counter well past saturation.
    for (int i = 0; i < 16; i++) cycle("t6 fill", 1'b1, 16'(16'h80 + i), $urandom, 1'b0);
    for (int i = 0; i < 300; i++) cycle("t6 drop", 1'b1, 16'h0090, $urandom, 1'b0);
    check_val("t6 drop_count sat", 64'(bus.drop_count), 64'd255);
    idle("t6 hold", 3, 1'b0);
    cycle("t6 reject", 1'b1, 16'h0200, 32'h0, 1'b0);
    idle("t6 drain", 18, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
